systolic_output_deskew: RTL and testbench

- Sits at the south edge of the systolic array, on the opposite side from the input skew chains built from single-stage registers.
- Column j of the array emits its result j cycles after column 0. This block realigns the N staggered column outputs into one row vector.
- Aligned rows are buffered in a small FIFO and handed downstream with a valid/ready handshake.
- It reports occupancy and credit so the array controller can throttle row issue.

---
 rtl/systolic_output_deskew.sv | 115 +++++++++++
 tb/tb_systolic_output_deskew.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_deskew.sv
// Realigns the staggered column results leaving the south edge of a systolic array
// into row vectors, buffers them in a small FIFO and hands them on with valid/ready.
module systolic_output_deskew #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [N*WIDTH-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int VS_W  = (N > 1) ? N - 1 : 1;
    localparam int CNT_W = $clog2(DEPTH + N) + 1;

    logic [VS_W-1:0]    valid_sr;
    logic               push;
    logic [N*WIDTH-1:0] aligned_row;

    // Row-valid tracks column 0 down to the point where the last column arrives.
    if (N == 1) begin : g_no_sr
        assign valid_sr = '0;
        assign push     = in_valid;
    end else begin : g_sr
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value and the chain really shifts.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_sr <= '0;
            end else begin
                valid_sr[0] <= in_valid;
                for (int k = 1; k < VS_W; k++) valid_sr[k] <= valid_sr[k-1];
            end
        end
        assign push = valid_sr[VS_W-1];
    end

    // Early columns are delayed more, so every column lines up with the last one.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int STAGES = N - 1 - j;
        if (STAGES == 0) begin : g_pass
            assign aligned_row[j*WIDTH +: WIDTH] = in_data[j*WIDTH +: WIDTH];
        end else begin : g_dly
            logic [WIDTH-1:0] pipe [STAGES];
            // NOTE: pure data pipes and FIFO storage carry no reset; the valid
            // bits and the FIFO level decide whether their contents mean anything.
            always_ff @(posedge clk) begin
                pipe[0] <= in_data[j*WIDTH +: WIDTH];
                for (int k = 1; k < STAGES; k++) pipe[k] <= pipe[k-1];
            end
            assign aligned_row[j*WIDTH +: WIDTH] = pipe[STAGES-1];
        end
    end

    logic [N*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= aligned_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    assign out_valid  = (level != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    logic [CNT_W-1:0] inflight;

    // NOTE: every combinational output gets its default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < VS_W; k++) inflight = inflight + CNT_W'(valid_sr[k]);
    end

    // Rows already in the skew pipe will land regardless, so they count as used.
    assign almost_full = (CNT_W'(level) + inflight) >= CNT_W'(DEPTH - 1);

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Randomized and directed bench for systolic_output_deskew, checked against a
// cycle-history/queue model of row alignment and FIFO behaviour.
module tb_systolic_output_deskew;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DW    = N * WIDTH;
    localparam int HIST  = 8192;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [DW-1:0]           in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DW-1:0]           out_data;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    almost_full;
    logic                    overflow;

    systolic_output_deskew #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .almost_full(almost_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: input history per cycle since reset, plus a queue of buffered rows.
    logic [DW-1:0] rowq [$];
    bit            m_ovf;
    int            cyc;
    bit            vh [HIST];
    logic [DW-1:0] dh [HIST];

    function automatic int inflight();
        int n = 0;
        for (int k = 1; k < N; k++)
            if (cyc - k >= 0 && vh[cyc-k]) n++;
        return n;
    endfunction

    task automatic model_reset();
        rowq.delete();
        m_ovf = 1'b0;
        cyc   = 0;
        for (int i = 0; i < HIST; i++) vh[i] = 1'b0;
    endtask

    // Called just after a falling edge: drive, check, advance model, move to next falling edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        logic [DW-1:0] row;
        bit do_push, do_pop;
        int t0;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        check("out_valid",   64'(out_valid),   64'(rowq.size() != 0));
        check("out_data",    64'(out_data),    rowq.size() != 0 ? 64'(rowq[0]) : 64'd0);
        check("fifo_level",  64'(fifo_level),  64'(rowq.size()));
        check("almost_full", 64'(almost_full), 64'((rowq.size() + inflight()) >= DEPTH - 1));
        check("overflow",    64'(overflow),    64'(m_ovf));
        vh[cyc] = v;
        dh[cyc] = d;
        do_pop  = (rowq.size() != 0) && r;
        do_push = (cyc >= N - 1) && vh[cyc-N+1];
        row = '0;
        if (do_push) begin
            t0 = cyc - N + 1;
            for (int j = 0; j < N; j++) row[j*WIDTH +: WIDTH] = dh[t0+j][j*WIDTH +: WIDTH];
        end
        if (do_pop) void'(rowq.pop_front());
        if (do_push) begin
            if (rowq.size() < DEPTH) rowq.push_back(row);
            else m_ovf = 1'b1;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    task automatic drain();
        for (int i = 0; i < 8; i++) step(1'b0, rnd_row(), 1'b1);
    endtask

    initial begin
        logic [DW-1:0] d;
        int issued;

        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    64'(out_data),    64'd0);
        check("rst_fifo_level",  64'(fifo_level),  64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_overflow",    64'(overflow),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single row: column j live only at cycle j.
        for (int t = 0; t < 7; t++) begin
            if (t == 3) check("single_early", 64'(out_valid), 64'd0);
            if (t == 4) begin
                check("single_valid", 64'(out_valid), 64'd1);
                check("single_data",  64'(out_data),  64'h1003_1002_1001_1000);
            end
            for (int j = 0; j < N; j++)
                d[j*WIDTH +: WIDTH] = (t == j) ? WIDTH'(16'h1000 + j) : WIDTH'(16'hDEAD);
            step(t == 0, d, 1'b1);
        end

        // Streaming: 8 back-to-back rows, column j of row r = r*16+j.
        for (int c = 0; c < 14; c++) begin
            for (int j = 0; j < N; j++)
                d[j*WIDTH +: WIDTH] = (c - j >= 0 && c - j < 8) ? WIDTH'((c - j) * 16 + j) : WIDTH'(0);
            if (c >= 4 && c < 12) check("stream_valid", 64'(out_valid), 64'd1);
            step(c < 8, d, 1'b1);
        end

        // Credit: issue only while almost_full is low, with the sink stalled.
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (!almost_full) begin
                issued++;
                step(1'b1, rnd_row(), 1'b0);
            end else begin
                step(1'b0, rnd_row(), 1'b0);
            end
        end
        check("credit_issued",   64'(issued),     64'd3);
        check("credit_level",    64'(fifo_level), 64'd3);
        check("credit_overflow", 64'(overflow),   64'd0);
        drain();

        // Full FIFO with a push and a pop in the same cycle.
        for (int c = 0; c < 9; c++) step(c < 5, rnd_row(), c == 7);
        check("fullpp_level",    64'(fifo_level), 64'd4);
        check("fullpp_overflow", 64'(overflow),   64'd0);
        drain();

        // Overflow: five rows into a stalled four-entry FIFO.
        for (int c = 0; c < 10; c++) step(c < 5, rnd_row(), 1'b0);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_flag",  64'(overflow),   64'd1);
        drain();
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Async reset with two rows buffered and two in flight.
        for (int c = 0; c < 5; c++) step(c < 4, rnd_row(), 1'b0);
        check("prerst_level", 64'(fifo_level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid",   64'(out_valid),   64'd0);
        check("arst_fifo_level",  64'(fifo_level),  64'd0);
        check("arst_almost_full", 64'(almost_full), 64'd0);
        check("arst_overflow",    64'(overflow),    64'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) check("postrst_early", 64'(out_valid), 64'd0);
            if (c == 4) check("postrst_valid", 64'(out_valid), 64'd1);
            step(c == 0, rnd_row(), c >= 5);
        end

        // Randomized traffic, occasionally ignoring almost_full to provoke drops.
        for (int c = 0; c < 3000; c++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0) && (!almost_full || $urandom_range(0, 7) == 0);
            step(v, rnd_row(), $urandom_range(0, 1) == 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
